// File: rtl/draw_sequencer_if.sv
// Bus between draw_sequencer, the three pixel-walking draw units and the VGA adapter write port.
interface draw_sequencer_if;
  logic       req_brd, req_dig, req_cur;
  logic       done_brd, done_dig, done_cur;
  logic [9:0] x_brd, x_dig, x_cur;
  logic [8:0] y_brd, y_dig, y_cur;
  logic [2:0] col_brd, col_dig, col_cur;
  logic       en_brd, en_dig, en_cur;
  logic [9:0] vga_x;
  logic [8:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic [1:0] active;
  logic       busy;
  logic       timeout_err;

  modport master (
    input  req_brd, req_dig, req_cur,
    input  done_brd, done_dig, done_cur,
    input  x_brd, x_dig, x_cur,
    input  y_brd, y_dig, y_cur,
    input  col_brd, col_dig, col_cur,
    output en_brd, en_dig, en_cur,
    output vga_x, vga_y, vga_colour, plot,
    output active, busy, timeout_err
  );

  modport slave (
    output req_brd, req_dig, req_cur,
    output done_brd, done_dig, done_cur,
    output x_brd, x_dig, x_cur,
    output y_brd, y_dig, y_cur,
    output col_brd, col_dig, col_cur,
    input  en_brd, en_dig, en_cur,
    input  vga_x, vga_y, vga_colour, plot,
    input  active, busy, timeout_err
  );
endinterface

// File: rtl/draw_sequencer.sv
// Fixed-priority arbiter for the board/digit/cursor draw units sharing the VGA write port.
// Grants one unit at a time, pipelines its pixels past the ROM colour latency, aborts hung units.
module draw_sequencer #(
  parameter int unsigned TIMEOUT = 65535
) (
  input logic              clk,
  input logic              reset,
  draw_sequencer_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  localparam logic [16:0] TimeoutCnt = 17'(TIMEOUT);

  state_e      state_q, state_d;
  logic [2:0]  pend_q, pend_d, req_vec, grant;
  logic [1:0]  active_q, active_d;
  logic [16:0] wdog_q, wdog_d;
  logic        flush_q, flush_d;
  logic        timeout_q, timeout_set;
  logic        run;

  logic        s1_v_q;
  logic [9:0]  s1_x_q;
  logic [8:0]  s1_y_q;
  logic [1:0]  s1_sel_q;

  logic        plot_q;
  logic [9:0]  vga_x_q;
  logic [8:0]  vga_y_q;
  logic [2:0]  colour_q;

  logic [9:0]  unit_x;
  logic [8:0]  unit_y;
  logic        unit_done;
  logic [2:0]  unit_col;

  assign req_vec = {bus.req_cur, bus.req_dig, bus.req_brd};
  assign run     = (state_q == StRun);

  always_comb begin
    unit_x    = '0;
    unit_y    = '0;
    unit_done = 1'b0;
    case (active_q)
      2'd1:    begin unit_x = bus.x_brd; unit_y = bus.y_brd; unit_done = bus.done_brd; end
      2'd2:    begin unit_x = bus.x_dig; unit_y = bus.y_dig; unit_done = bus.done_dig; end
      2'd3:    begin unit_x = bus.x_cur; unit_y = bus.y_cur; unit_done = bus.done_cur; end
      default: begin end
    endcase
  end

  // Colour arrives a cycle after x/y, so it follows the unit latched with the stage-1 pixel.
  always_comb begin
    unit_col = '0;
    case (s1_sel_q)
      2'd1:    unit_col = bus.col_brd;
      2'd2:    unit_col = bus.col_dig;
      2'd3:    unit_col = bus.col_cur;
      default: unit_col = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    wdog_d      = '0;
    flush_d     = 1'b0;
    grant       = '0;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pend_q[0]) begin
          grant    = 3'b001;
          active_d = 2'd1;
        end else if (pend_q[1]) begin
          grant    = 3'b010;
          active_d = 2'd2;
        end else if (pend_q[2]) begin
          grant    = 3'b100;
          active_d = 2'd3;
        end
        if (|pend_q) state_d = StRun;
      end
      StRun: begin
        if (unit_done) begin
          state_d = StFlush;
        end else if (wdog_q + 17'd1 == TimeoutCnt) begin
          state_d     = StFlush;
          timeout_set = 1'b1;
        end else begin
          wdog_d = wdog_q + 17'd1;
        end
      end
      StFlush: begin
        flush_d = ~flush_q;
        if (flush_q) begin
          state_d  = StIdle;
          active_d = 2'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A request on the grant edge survives the clear, queueing a redraw.
  assign pend_d = (pend_q & ~grant) | req_vec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pend_q    <= '0;
      active_q  <= '0;
      wdog_q    <= '0;
      flush_q   <= 1'b0;
      timeout_q <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      s1_sel_q  <= '0;
      plot_q    <= 1'b0;
      vga_x_q   <= '0;
      vga_y_q   <= '0;
      colour_q  <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      active_q  <= active_d;
      wdog_q    <= wdog_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_q | timeout_set;
      s1_v_q    <= run;
      if (run) begin
        s1_x_q   <= unit_x;
        s1_y_q   <= unit_y;
        s1_sel_q <= active_q;
      end
      plot_q   <= s1_v_q;
      vga_x_q  <= s1_x_q;
      vga_y_q  <= s1_y_q;
      colour_q <= unit_col;
    end
  end

  assign bus.en_brd      = run && (active_q == 2'd1);
  assign bus.en_dig      = run && (active_q == 2'd2);
  assign bus.en_cur      = run && (active_q == 2'd3);
  assign bus.vga_x       = vga_x_q;
  assign bus.vga_y       = vga_y_q;
  assign bus.vga_colour  = colour_q;
  assign bus.plot        = plot_q;
  assign bus.active      = active_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: full board walk, priority, redraw, latency, watchdog, reset.
module tb_draw_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  int who_en, who_act, en_cyc, plot_cnt, bad_plot, onehot_err, idle_gap;

  draw_sequencer_if bus ();
  draw_sequencer_if wbus ();

  draw_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  draw_sequencer #(
    .TIMEOUT (100)
  ) dut_wd (
    .clk   (clk),
    .reset (reset),
    .bus   (wbus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] pix_col(input int x, input int y);
    return 3'((x + y) % 8);
  endfunction

  function automatic int en_idx();
    if (bus.en_brd) return 1;
    if (bus.en_dig) return 2;
    if (bus.en_cur) return 3;
    return 0;
  endfunction

  function automatic logic en_of(input int u);
    case (u)
      1:       return bus.en_brd;
      2:       return bus.en_dig;
      3:       return bus.en_cur;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_unit(input int u, input int x, input int y, input logic d);
    case (u)
      1: begin bus.x_brd = 10'(x); bus.y_brd = 9'(y); bus.done_brd = d; end
      2: begin bus.x_dig = 10'(x); bus.y_dig = 9'(y); bus.done_dig = d; end
      3: begin bus.x_cur = 10'(x); bus.y_cur = 9'(y); bus.done_cur = d; end
      default: begin end
    endcase
  endtask

  task automatic set_col(input int u, input logic [2:0] c);
    case (u)
      1: bus.col_brd = c;
      2: bus.col_dig = c;
      3: bus.col_cur = c;
      default: begin end
    endcase
  endtask

  task automatic set_req(input int u, input logic r);
    case (u)
      1: bus.req_brd = r;
      2: bus.req_dig = r;
      3: bus.req_cur = r;
      default: begin end
    endcase
  endtask

  // Plays whichever unit gets granted: walks npix pixels w wide, then holds done.
  // Every plot is checked against the pixel index it must carry (last one repeated).
  task automatic serve(input int npix, input int w, input int rereq_at);
    int px, cyc, done_cyc, cx, cy, pk, u;
    en_cyc = 0; plot_cnt = 0; bad_plot = 0; onehot_err = 0;
    cyc = 0;
    while (cyc < 10 && en_idx() == 0) begin
      step();
      cyc++;
    end
    who_en  = en_idx();
    who_act = int'(bus.active);
    u = who_en;
    px = 0; cx = 0; cy = 0; cyc = 0; done_cyc = -1;
    while (cyc < 40000 && bus.busy) begin
      if (int'(bus.en_brd) + int'(bus.en_dig) + int'(bus.en_cur) > 1) onehot_err++;
      if (bus.plot) begin
        pk = (plot_cnt < npix) ? plot_cnt : npix - 1;
        if (bus.vga_x !== 10'(pk % w) || bus.vga_y !== 9'(pk / w) ||
            bus.vga_colour !== pix_col(pk % w, pk / w)) bad_plot++;
        plot_cnt++;
      end
      set_req(u, cyc == rereq_at);
      set_col(u, pix_col(cx, cy));
      if (en_of(u)) begin
        en_cyc++;
        if (px < npix) begin
          cx = px % w;
          cy = px / w;
          px++;
          set_unit(u, cx, cy, 1'b0);
        end else begin
          set_unit(u, cx, cy, 1'b1);
          if (done_cyc < 0) done_cyc = cyc;
        end
      end else begin
        set_unit(u, cx, cy, 1'b0);
      end
      step();
      cyc++;
    end
    idle_gap = cyc - done_cyc;
    set_unit(u, 0, 0, 1'b0);
    set_req(u, 1'b0);
  endtask

  initial begin
    int cnt, cyc;
    reset = 1'b0;
    for (int u = 1; u <= 3; u++) begin
      set_unit(u, 0, 0, 1'b0);
      set_col(u, 3'd0);
      set_req(u, 1'b0);
    end
    wbus.req_brd = 0; wbus.req_dig = 0; wbus.req_cur = 0;
    wbus.done_brd = 0; wbus.done_dig = 0; wbus.done_cur = 0;
    wbus.x_brd = 0; wbus.x_dig = 0; wbus.x_cur = 0;
    wbus.y_brd = 0; wbus.y_dig = 0; wbus.y_cur = 0;
    wbus.col_brd = 0; wbus.col_dig = 0; wbus.col_cur = 0;
    #2 reset = 1'b1;
    step();
    step();

    check("rst_en",      {bus.en_brd, bus.en_dig, bus.en_cur}, 0);
    check("rst_plot",    bus.plot, 0);
    check("rst_vga_x",   bus.vga_x, 0);
    check("rst_vga_y",   bus.vga_y, 0);
    check("rst_colour",  bus.vga_colour, 0);
    check("rst_active",  bus.active, 0);
    check("rst_busy",    bus.busy, 0);
    check("rst_tmo",     bus.timeout_err, 0);
    reset = 1'b0;
    step();

    // Full 320x120 board walk.
    bus.req_brd = 1'b1;
    step();
    bus.req_brd = 1'b0;
    check("req_no_en_yet", bus.en_brd, 0);
    serve(38400, 320, -1);
    check("brd_who_en",   who_en, 1);
    check("brd_who_act",  who_act, 1);
    check("brd_en_cyc",   en_cyc, 38401);
    check("brd_plots",    plot_cnt, 38401);
    check("brd_bad_plot", bad_plot, 0);
    check("brd_idle_gap", idle_gap, 3);
    check("brd_active0",  bus.active, 0);
    check("brd_tmo",      bus.timeout_err, 0);

    // Simultaneous requests: brd, dig, cur in turn.
    bus.req_brd = 1'b1; bus.req_dig = 1'b1; bus.req_cur = 1'b1;
    step();
    bus.req_brd = 1'b0; bus.req_dig = 1'b0; bus.req_cur = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      serve(4, 4, -1);
      check("pri_who_en",  who_en, k);
      check("pri_who_act", who_act, k);
      check("pri_plots",   plot_cnt, 5);
      check("pri_bad",     bad_plot, 0);
      check("pri_onehot",  onehot_err, 0);
      check("pri_gap",     idle_gap, 3);
    end
    step();
    check("pri_drained", bus.busy, 0);

    // Own re-request mid-run queues exactly one redraw.
    bus.req_dig = 1'b1;
    step();
    bus.req_dig = 1'b0;
    serve(6, 6, 3);
    check("rereq_first", who_en, 2);
    serve(6, 6, -1);
    check("rereq_second", who_en, 2);
    check("rereq_plots",  plot_cnt, 7);
    step();
    step();
    check("rereq_once", bus.busy, 0);

    // Latency with done on the first RUN cycle.
    bus.req_dig = 1'b1;
    step();
    bus.req_dig = 1'b0;
    step();
    check("lat_en", bus.en_dig, 1);
    set_unit(2, 5, 7, 1'b1);
    step();
    check("lat_c1_plot", bus.plot, 0);
    check("lat_c1_en",   bus.en_dig, 0);
    set_col(2, 3'b101);
    set_unit(2, 5, 7, 1'b0);
    step();
    check("lat_plot",   bus.plot, 1);
    check("lat_x",      bus.vga_x, 5);
    check("lat_y",      bus.vga_y, 7);
    check("lat_colour", bus.vga_colour, 3'b101);
    step();
    check("lat_single_plot", bus.plot, 0);
    check("lat_idle",        bus.busy, 0);
    set_unit(2, 0, 0, 1'b0);

    // Watchdog on the TIMEOUT=100 instance; dig is queued behind the hung cursor.
    wbus.req_cur = 1'b1;
    step();
    wbus.req_cur = 1'b0;
    step();
    check("wd_grant", wbus.en_cur, 1);
    wbus.req_dig = 1'b1;
    cnt = 0;
    cyc = 0;
    while (cyc < 300 && wbus.en_cur) begin
      cnt++;
      step();
      wbus.req_dig = 1'b0;
      cyc++;
    end
    check("wd_run_cycles", cnt, 100);
    check("wd_err_set",    wbus.timeout_err, 1);
    cyc = 0;
    while (cyc < 10 && !wbus.en_dig) begin
      step();
      cyc++;
    end
    check("wd_next_grant", wbus.en_dig, 1);
    check("wd_gap",        cyc, 3);
    wbus.done_dig = 1'b1;
    step();
    wbus.done_dig = 1'b0;
    step();
    step();
    check("wd_dig_done",   wbus.busy, 0);
    check("wd_err_sticky", wbus.timeout_err, 1);

    // Asynchronous reset mid-run, with a dig request pending that must be lost.
    bus.req_brd = 1'b1;
    step();
    bus.req_brd = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      set_unit(1, i, 2, 1'b0);
      set_req(2, i == 1);
      step();
    end
    set_req(2, 1'b0);
    check("arst_pre_plot", bus.plot, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_en",     {bus.en_brd, bus.en_dig, bus.en_cur}, 0);
    check("arst_plot",   bus.plot, 0);
    check("arst_busy",   bus.busy, 0);
    check("arst_active", bus.active, 0);
    check("arst_wd_tmo", wbus.timeout_err, 0);
    step();
    reset = 1'b0;
    set_unit(1, 0, 0, 1'b0);
    step();
    step();
    step();
    check("arst_pend_lost", bus.busy, 0);
    bus.req_brd = 1'b1;
    step();
    bus.req_brd = 1'b0;
    serve(2, 2, -1);
    check("arst_regrant", who_en, 1);
    check("arst_plots",   plot_cnt, 3);
    check("arst_bad",     bad_plot, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
